ctrl_pipe_decoder: RTL

Parametrised RV32I(+M) instruction decoder with its own ID/EX, EX/MEM and MEM/WB control pipeline registers. It sits between the IF/ID instruction register and the datapath. Compared with the fixed single-flush controller, it adds:
- optional M-extension and JAL/JALR decode
- a global stall (hold)
- separate EX-only and full flushes
- built-in load-use bubble insertion
- rd tracking per stage
- illegal-instruction flag and sticky halt

---
 rtl/ctrl_pipe_decoder_pkg.sv | 100 ++++++++++
 rtl/ctrl_pipe_decoder_rv_decode.sv | 126 ++++++++++++
 rtl/ctrl_pipe_decoder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_decoder_pkg.sv
// Shared encodings and per-stage control bundles for the RV32I(+M) control pipeline.
package ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b010;
   localparam logic [2:0] BR_NE   = 3'b101;
   localparam logic [2:0] BR_LT   = 3'b100;
   localparam logic [2:0] BR_GE   = 3'b011;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_JAL  = 2'b01;
   localparam logic [1:0] JMP_JALR = 2'b10;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_H  = 3'b011;
   localparam logic [2:0] LD_BU = 3'b010;
   localparam logic [2:0] LD_HU = 3'b100;

   localparam logic [2:0] ST_W = 3'b000;
   localparam logic [2:0] ST_B = 3'b010;
   localparam logic [2:0] ST_H = 3'b100;

   localparam logic       SRC1_RS2  = 1'b0;
   localparam logic       SRC1_IMM  = 1'b1;
   localparam logic [1:0] SRC2_RS1  = 2'b00;
   localparam logic [1:0] SRC2_PC   = 2'b01;
   localparam logic [1:0] SRC2_ZERO = 2'b10;

   typedef struct packed {
      logic [2:0] branch;
      logic [1:0] jump;
      logic [3:0] alu_op;
      logic       alu_src1;
      logic [1:0] alu_src2;
      logic       uors;
      logic       mext;
      logic       mem_read;
      logic       illegal;
      logic       ecall;
   } ex_t;

   typedef struct packed {
      logic       mem_write;
      logic       mem_to_reg;
      logic [2:0] ld_mode;
      logic [2:0] st_mode;
   } mem_t;

   typedef struct packed {
      logic       reg_write;
      logic [4:0] rd;
   } wb_t;

   typedef struct packed {
      ex_t  ex;
      mem_t mem;
      wb_t  wb;
   } ctrl_t;

   typedef struct packed {
      mem_t mem;
      wb_t  wb;
   } mw_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } halt_st_e;

   // Returns {legal, ld_mode} for a load funct3.
   function automatic logic [3:0] ld_mode_f(input logic [2:0] f3);
      case (f3)
         3'b000:  return {1'b1, LD_B};
         3'b001:  return {1'b1, LD_H};
         3'b010:  return {1'b1, LD_W};
         3'b100:  return {1'b1, LD_BU};
         3'b101:  return {1'b1, LD_HU};
         default: return {1'b0, LD_W};
      endcase
   endfunction

endpackage

// File: rtl/ctrl_pipe_decoder_rv_decode.sv
// Combinational RV32I(+M) decode of one instruction word into a control bundle.
module rv_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned EN_MEXT = 1,
   parameter int unsigned EN_JUMP = 1
) (
   input  logic [31:0] i_instr,
   output ctrl_t       o_ctrl,
   output logic        o_uses_rs2
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic [4:0] w_rd;
   logic [3:0] w_ld;
   logic       w_bad;
   ctrl_t      w_c;

   assign w_opc = i_instr[6:0];
   assign w_f3  = i_instr[14:12];
   assign w_f7  = i_instr[31:25];
   assign w_rd  = i_instr[11:7];
   assign w_ld  = ld_mode_f(w_f3);

   always_comb begin
      w_c        = '0;
      w_bad      = 1'b0;
      o_uses_rs2 = 1'b0;
      case (w_opc)
         OPC_OP_IMM: begin
            w_c.ex.alu_src1  = SRC1_IMM;
            w_c.wb.reg_write = 1'b1;
            w_c.ex.alu_op    = {1'b0, w_f3};
            if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               if (w_f7 != F7_BASE && w_f7 != F7_ALT) w_bad = 1'b1;
               else if (w_f3 == 3'b101)               w_c.ex.alu_op[3] = w_f7[5];
            end
         end
         OPC_OP: begin
            o_uses_rs2       = 1'b1;
            w_c.ex.alu_src1  = SRC1_RS2;
            w_c.wb.reg_write = 1'b1;
            w_c.ex.alu_op    = {1'b0, w_f3};
            if (w_f7 == F7_ALT) begin
               if (w_f3 == 3'b000 || w_f3 == 3'b101) w_c.ex.alu_op[3] = 1'b1;
               else                                  w_bad = 1'b1;
            end else if (w_f7 == F7_MEXT) begin
               if (EN_MEXT != 0) w_c.ex.mext = 1'b1;
               else              w_bad = 1'b1;
            end else if (w_f7 != F7_BASE) begin
               w_bad = 1'b1;
            end
         end
         OPC_LUI: begin
            w_c.ex.alu_src1  = SRC1_IMM;
            w_c.ex.alu_src2  = SRC2_ZERO;
            w_c.wb.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            w_c.ex.alu_src1  = SRC1_IMM;
            w_c.ex.alu_src2  = SRC2_PC;
            w_c.wb.reg_write = 1'b1;
         end
         OPC_BRANCH: begin
            o_uses_rs2      = 1'b1;
            w_c.ex.alu_src1 = SRC1_RS2;
            w_c.ex.alu_op   = {1'b0, w_f3};
            w_c.ex.uors     = w_f3[1];
            case (w_f3)
               3'b000:        w_c.ex.branch = BR_EQ;
               3'b001:        w_c.ex.branch = BR_NE;
               3'b100, 3'b110: w_c.ex.branch = BR_LT;
               3'b101, 3'b111: w_c.ex.branch = BR_GE;
               default:       w_bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            w_c.ex.mem_read    = 1'b1;
            w_c.ex.alu_src1    = SRC1_IMM;
            w_c.mem.mem_to_reg = 1'b1;
            w_c.mem.ld_mode    = w_ld[2:0];
            w_c.wb.reg_write   = 1'b1;
            w_bad              = ~w_ld[3];
         end
         OPC_STORE: begin
            o_uses_rs2        = 1'b1;
            w_c.ex.alu_src1   = SRC1_IMM;
            w_c.mem.mem_write = 1'b1;
            case (w_f3)
               3'b000:  w_c.mem.st_mode = ST_B;
               3'b001:  w_c.mem.st_mode = ST_H;
               3'b010:  w_c.mem.st_mode = ST_W;
               default: w_bad = 1'b1;
            endcase
         end
         OPC_JAL: begin
            w_c.ex.jump      = JMP_JAL;
            w_c.ex.alu_src2  = SRC2_PC;
            w_c.wb.reg_write = 1'b1;
            w_bad            = (EN_JUMP == 0);
         end
         OPC_JALR: begin
            w_c.ex.jump      = JMP_JALR;
            w_c.ex.alu_src2  = SRC2_PC;
            w_c.wb.reg_write = 1'b1;
            w_bad            = (EN_JUMP == 0) || (w_f3 != 3'b000);
         end
         OPC_SYSTEM: begin
            if (i_instr == INSTR_ECALL) w_c.ex.ecall = 1'b1;
            else                        w_bad = 1'b1;
         end
         default: w_bad = 1'b1;
      endcase

      if (w_bad) w_c = '0;
      w_c.ex.illegal = w_bad;
      // A write to x0 is no write at all, so downstream hazard checks never match it.
      if (w_c.wb.reg_write && (w_rd != 5'd0)) w_c.wb.rd = w_rd;
      else                                    w_c.wb.reg_write = 1'b0;
   end

   assign o_ctrl = w_c;

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Decoder with ID/EX, EX/MEM, MEM/WB control registers, load-use bubbles and ECALL halt.
module ctrl_pipe_decoder
   import ctrl_pkg::*;
#(
   parameter int unsigned EN_MEXT     = 1,
   parameter int unsigned EN_JUMP     = 1,
   parameter int unsigned HALT_STICKY = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] instr_i,
   input  logic        id_valid_i,
   input  logic        stall_i,
   input  logic        flush_ex_i,
   input  logic        flush_all_i,
   output logic        load_use_o,
   output logic [2:0]  branch_ex,
   output logic [1:0]  jump_ex,
   output logic [3:0]  alu_op_ex,
   output logic        alu_src1_ex,
   output logic [1:0]  alu_src2_ex,
   output logic        uors_ex,
   output logic        mext_ex,
   output logic        mem_read_ex,
   output logic [4:0]  rd_ex,
   output logic [4:0]  rd_m,
   output logic [4:0]  rd_w,
   output logic        illegal_ex,
   output logic        mem_write_m,
   output logic        mem_to_reg_m,
   output logic        reg_write_m,
   output logic [2:0]  ld_mode_m,
   output logic [2:0]  st_mode_m,
   output logic        reg_write_w,
   output logic        halt_o
);

   ctrl_t      w_dec;
   logic       w_uses_rs2;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic       w_load_use;
   logic       w_kill_id;
   logic       w_halt_go;

   ctrl_t      r_ex;
   mw_t        r_m;
   wb_t        r_w;
   halt_st_e   r_st;
   logic       r_halt;

   rv_decode #(
      .EN_MEXT (EN_MEXT),
      .EN_JUMP (EN_JUMP)
   ) u_dec (
      .i_instr    (instr_i),
      .o_ctrl     (w_dec),
      .o_uses_rs2 (w_uses_rs2)
   );

   assign w_rs1 = instr_i[19:15];
   assign w_rs2 = instr_i[24:20];

   assign w_load_use = id_valid_i & r_ex.ex.mem_read & (r_ex.wb.rd != 5'd0) &
                       ((w_rs1 == r_ex.wb.rd) | (w_uses_rs2 & (w_rs2 == r_ex.wb.rd)));

   // Instructions behind an ECALL in EX are squashed so none slips past the halt.
   assign w_kill_id = ~id_valid_i | flush_ex_i | w_load_use | r_ex.ex.ecall |
                      ((HALT_STICKY != 0) && (r_st == ST_HALTED));

   assign w_halt_go = r_ex.ex.ecall & ~flush_all_i & ~stall_i;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ex <= '0;
         r_m  <= '0;
         r_w  <= '0;
      end else if (flush_all_i) begin
         r_ex <= '0;
         r_m  <= '0;
         r_w  <= r_m.wb;
      end else if (!stall_i) begin
         r_ex <= w_kill_id ? ctrl_t'('0) : w_dec;
         r_m  <= {r_ex.mem, r_ex.wb};
         r_w  <= r_m.wb;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_st   <= ST_RUN;
         r_halt <= 1'b0;
      end else if (!stall_i) begin
         if (r_st == ST_RUN) begin
            if (w_halt_go) begin
               r_st   <= ST_HALTED;
               r_halt <= 1'b1;
            end
         end else if (HALT_STICKY == 0) begin
            r_st   <= ST_RUN;
            r_halt <= 1'b0;
         end
      end
   end

   assign load_use_o   = w_load_use;
   assign branch_ex    = r_ex.ex.branch;
   assign jump_ex      = r_ex.ex.jump;
   assign alu_op_ex    = r_ex.ex.alu_op;
   assign alu_src1_ex  = r_ex.ex.alu_src1;
   assign alu_src2_ex  = r_ex.ex.alu_src2;
   assign uors_ex      = r_ex.ex.uors;
   assign mext_ex      = r_ex.ex.mext;
   assign mem_read_ex  = r_ex.ex.mem_read;
   assign illegal_ex   = r_ex.ex.illegal;
   assign rd_ex        = r_ex.wb.rd;
   assign mem_write_m  = r_m.mem.mem_write;
   assign mem_to_reg_m = r_m.mem.mem_to_reg;
   assign ld_mode_m    = r_m.mem.ld_mode;
   assign st_mode_m    = r_m.mem.st_mode;
   assign reg_write_m  = r_m.wb.reg_write;
   assign rd_m         = r_m.wb.rd;
   assign reg_write_w  = r_w.reg_write;
   assign rd_w         = r_w.rd;
   assign halt_o       = r_halt;

endmodule
